// File: rtl/timer_bank.sv
// timer_bank: bank of NUM_CH memory-mapped up-counting timers. Each channel
// has a reload value (TH), a count (TL), control/status (TCON) and an optional
// prescaler (PRE). Reaching 32'hFFFFFFFF and ticking once more reloads TL
// from TH. The wrap can raise an interrupt and can stop the channel in
// one-shot mode.
// Optional feature: define TIMER_BANK_PRESCALE_EN to build the per-channel
// prescaler. Without it, an enabled channel ticks every cycle and PRE reads 0.
module timer_bank #(
  parameter int unsigned NUM_CH    = 2,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRE_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irqout,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WOFF_W   = 30;
  localparam int unsigned CH_SEL_W = WOFF_W - 2;
  localparam logic [WOFF_W-1:0] STAT_WOFF = WOFF_W'(4 * NUM_CH);

  typedef struct packed {
    logic oneshot;
    logic pend;
    logic ie;
    logic en;
  } tcon_t;

  logic [WOFF_W-1:0] word_off;
  logic              aligned;

  logic [DATA_W-1:0] th_q   [NUM_CH];
  logic [DATA_W-1:0] tl_q   [NUM_CH];
  tcon_t             tcon_q [NUM_CH];
  tcon_t             tcon_d [NUM_CH];

  logic [NUM_CH-1:0] wr_th;
  logic [NUM_CH-1:0] wr_tl;
  logic [NUM_CH-1:0] wr_tcon;
  logic [NUM_CH-1:0] wr_pre;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] pend_vec;

`ifdef TIMER_BANK_PRESCALE_EN
  logic [PRE_W-1:0] pre_q [NUM_CH];
  logic [PRE_W-1:0] pc_q  [NUM_CH];
`endif

  // Word offset from the bank base; misaligned byte addresses never decode.
  assign word_off = addr[31:2] - BASE_ADDR[31:2];
  assign aligned  = (addr[1:0] == 2'b00);

  // Per-channel register write strobes.
  always_comb begin
    wr_th   = '0;
    wr_tl   = '0;
    wr_tcon = '0;
    wr_pre  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr && aligned && (word_off[WOFF_W-1:2] == CH_SEL_W'(c))) begin
        case (word_off[1:0])
          2'd0:    wr_th[c]   = 1'b1;
          2'd1:    wr_tl[c]   = 1'b1;
          2'd2:    wr_tcon[c] = 1'b1;
          default: wr_pre[c]  = 1'b1;
        endcase
      end
    end
  end

  // Tick generation and wrap detection.
  always_comb begin
    tick = '0;
    wrap = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
`ifdef TIMER_BANK_PRESCALE_EN
      tick[c] = tcon_q[c].en && (pc_q[c] == pre_q[c]);
`else
      tick[c] = tcon_q[c].en;
`endif
      wrap[c] = tick[c] && (tl_q[c] == 32'hFFFF_FFFF);
    end
  end

  // Next control/status: one-shot stop, CPU load, W1C, then wrap-set wins.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      tcon_d[c] = tcon_q[c];
      if (wrap[c] && tcon_q[c].oneshot) begin
        tcon_d[c].en = 1'b0;
      end
      if (wr_tcon[c]) begin
        tcon_d[c].en      = wdata[0];
        tcon_d[c].ie      = wdata[1];
        tcon_d[c].oneshot = wdata[3];
        if (wdata[2]) begin
          tcon_d[c].pend = 1'b0;
        end
      end
      if (wrap[c] && tcon_q[c].ie) begin
        tcon_d[c].pend = 1'b1;
      end
    end
  end

  // Channel registers: CPU write to TL takes precedence over the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        th_q[c]   <= '0;
        tl_q[c]   <= '0;
        tcon_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_th[c]) begin
          th_q[c] <= wdata;
        end
        if (wr_tl[c]) begin
          tl_q[c] <= wdata;
        end else if (tick[c]) begin
          tl_q[c] <= wrap[c] ? th_q[c] : tl_q[c] + 32'd1;
        end
        tcon_q[c] <= tcon_d[c];
      end
    end
  end

`ifdef TIMER_BANK_PRESCALE_EN
  // Prescaler: counts while enabled, restarts on tick and on a fresh enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        pre_q[c] <= '0;
        pc_q[c]  <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_pre[c]) begin
          pre_q[c] <= wdata[PRE_W-1:0];
        end
        if (wr_tcon[c] && wdata[0] && !tcon_q[c].en) begin
          pc_q[c] <= '0;
        end else if (tcon_q[c].en) begin
          pc_q[c] <= tick[c] ? '0 : pc_q[c] + PRE_W'(1);
        end
      end
    end
  end
`endif

  // Interrupt outputs straight from registered pending and enable bits.
  always_comb begin
    pend_vec = '0;
    irq_vec  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pend_vec[c] = tcon_q[c].pend;
      irq_vec[c]  = tcon_q[c].pend && tcon_q[c].ie;
    end
  end

  assign irqout = |irq_vec;

  // Combinational read mux; zero when idle or unmapped.
  always_comb begin
    rdata = '0;
    if (rd && aligned) begin
      if (word_off == STAT_WOFF) begin
        rdata = DATA_W'(pend_vec);
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (word_off[WOFF_W-1:2] == CH_SEL_W'(c)) begin
          case (word_off[1:0])
            2'd0:    rdata = th_q[c];
            2'd1:    rdata = tl_q[c];
            2'd2:    rdata = DATA_W'(tcon_q[c]);
`ifdef TIMER_BANK_PRESCALE_EN
            default: rdata = DATA_W'(pre_q[c]);
`else
            default: rdata = '0;
`endif
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: scoreboard bench for timer_bank. Reads push expectations into
// a queue; a negedge monitor pops and compares rdata/irq_vec/irqout.
// Expectations come from a behavioural register model or from fixed constants.
module tb_timer_bank;

  localparam int unsigned NUM_CH = 2;
  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam int unsigned PRE_W  = 8;
  localparam int unsigned PC_MOD = 1 << PRE_W;
  localparam logic [31:0] STAT   = BASE + 32'(16 * NUM_CH);

  logic              clk = 1'b0;
  logic              reset;
  logic              rd;
  logic              wr;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              irqout;
  logic [NUM_CH-1:0] irq_vec;

  timer_bank #(
    .NUM_CH   (NUM_CH),
    .BASE_ADDR(BASE),
    .PRE_W    (PRE_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irqout (irqout),
    .irq_vec(irq_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] irq;
    string             name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic started = 1'b0;
  logic end_req = 1'b0;

  // Behavioural register model.
  logic [31:0] m_th   [NUM_CH];
  logic [31:0] m_tl   [NUM_CH];
  logic        m_en   [NUM_CH];
  logic        m_ie   [NUM_CH];
  logic        m_pend [NUM_CH];
  logic        m_os   [NUM_CH];
  int unsigned m_pre  [NUM_CH];
  int unsigned m_pc   [NUM_CH];

  function automatic void model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_en[i] = 1'b0; m_ie[i] = 1'b0;
      m_pend[i] = 1'b0; m_os[i] = 1'b0; m_pre[i] = 0; m_pc[i] = 0;
    end
  endfunction

  // One clock edge: ticks and wraps from old state, then the CPU write,
  // then a wrap with interrupts enabled sets pending regardless of W1C.
  function automatic void model_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        tk     [NUM_CH];
    logic        wrp    [NUM_CH];
    logic        old_en [NUM_CH];
    logic        old_ie [NUM_CH];
    int unsigned off;
    int unsigned c;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef TIMER_BANK_PRESCALE_EN
      tk[i] = m_en[i] && (m_pc[i] == m_pre[i]);
`else
      tk[i] = m_en[i];
`endif
      wrp[i]    = tk[i] && (m_tl[i] == 32'hFFFF_FFFF);
      old_en[i] = m_en[i];
      old_ie[i] = m_ie[i];
      if (m_en[i]) m_pc[i] = tk[i] ? 0 : (m_pc[i] + 1) % PC_MOD;
      if (tk[i]) m_tl[i] = wrp[i] ? m_th[i] : m_tl[i] + 32'd1;
      if (wrp[i] && m_os[i]) m_en[i] = 1'b0;
    end
    off = a - BASE;
    if (w && (off % 4 == 0) && (off < 16 * NUM_CH)) begin
      c = off / 16;
      case ((off % 16) / 4)
        0: m_th[c] = d;
        1: m_tl[c] = d;
        2: begin
          if (d[0] && !old_en[c]) m_pc[c] = 0;
          m_en[c] = d[0];
          m_ie[c] = d[1];
          m_os[c] = d[3];
          if (d[2]) m_pend[c] = 1'b0;
        end
        default: begin
`ifdef TIMER_BANK_PRESCALE_EN
          m_pre[c] = d % PC_MOD;
`endif
        end
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (wrp[i] && old_ie[i]) m_pend[i] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned off;
    int unsigned c;
    logic [31:0] v;
    off = a - BASE;
    v   = '0;
    if (off % 4 != 0) return '0;
    if (off == 16 * NUM_CH) begin
      for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i];
      return v;
    end
    if (off >= 16 * NUM_CH) return '0;
    c = off / 16;
    case ((off % 16) / 4)
      0: v = m_th[c];
      1: v = m_tl[c];
      2: v = {28'b0, m_os[c], m_pend[c], m_ie[c], m_en[c]};
      default: begin
`ifdef TIMER_BANK_PRESCALE_EN
        v = 32'(m_pre[c]);
`else
        v = '0;
`endif
      end
    endcase
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] model_irq();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i] & m_ie[i];
    return v;
  endfunction

  // One bus cycle; called #1 after a posedge, returns #1 after the next one.
  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic use_const, input logic [31:0] c_rd,
                     input logic [NUM_CH-1:0] c_irq, input string nm);
    exp_t x;
    rd = r; wr = w; addr = a; wdata = d;
    if (r) begin
      x.rdata = use_const ? c_rd  : model_read(a);
      x.irq   = use_const ? c_irq : model_irq();
      x.name  = nm;
      q.push_back(x);
    end
    @(posedge clk);
    if (reset) model_step(w, a, d);
    else       model_clear();
    #1;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, "");
  endtask

  task automatic wreg(input logic [31:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d, 1'b0, '0, '0, "");
  endtask

  task automatic chk(input logic [31:0] a, input logic [31:0] v, input logic [NUM_CH-1:0] irq,
                     input string nm);
    bus(1'b1, 1'b0, a, '0, 1'b1, v, irq, nm);
  endtask

  task automatic mread(input logic [31:0] a);
    bus(1'b1, 1'b0, a, '0, 1'b0, '0, '0, "model_rd");
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    model_clear();
    idle();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 7) return BASE + 32'(16 * $urandom_range(0, NUM_CH - 1)) + 32'(4 * $urandom_range(0, 3));
    if (k == 7) return STAT;
    if (k == 8) return BASE + 32'($urandom_range(0, 16 * NUM_CH + 8));
    return $urandom;
  endfunction

  function automatic logic [31:0] rand_data(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    case (off[3:2])
      2'd0: return ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      2'd1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 24));
      2'd2: return 32'($urandom_range(0, 15)) | 32'($urandom_range(0, 2) != 0)
                   | (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FF00) : 32'h0);
      default: return ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
    endcase
  endfunction

  // Monitor: compares every read against the queue head; idle rdata must be 0.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (rd === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty: read at addr=%h with no expectation queued", addr);
        end else begin
          e = q.pop_front();
          if (rdata !== e.rdata || irq_vec !== e.irq || irqout !== (|e.irq)) begin
            errors++;
            $display("FAIL %s addr=%h: got rdata=%h irq_vec=%b irqout=%b, expected rdata=%h irq_vec=%b irqout=%b",
                     e.name, addr, rdata, irq_vec, irqout, e.rdata, e.irq, |e.irq);
          end
        end
      end else if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL idle_rdata: got rdata=%h with rd=0, expected 00000000", rdata);
      end
      if (end_req) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
      end
    end
  end

  initial begin
    logic        r;
    logic        w;
    logic [31:0] a;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    model_clear();
    @(posedge clk);
    #1;
    started = 1'b1;

    // Reset state
    chk(BASE + 32'h0, 32'h0, 2'b00, "rst_th0");
    chk(BASE + 32'h4, 32'h0, 2'b00, "rst_tl0");
    chk(BASE + 32'h8, 32'h0, 2'b00, "rst_tcon0");
    chk(STAT,         32'h0, 2'b00, "rst_stat");
    reset = 1'b1;

    // Ch0 reload wrap with interrupt
    wreg(BASE + 32'h0, 32'hFFFF_FFF0);
    wreg(BASE + 32'h4, 32'hFFFF_FFFD);
    wreg(BASE + 32'hC, 32'h0);
    wreg(BASE + 32'h8, 32'h3);
    idle();
    idle();
    chk(BASE + 32'h4, 32'hFFFF_FFFF, 2'b00, "wrap_before");
    chk(BASE + 32'h4, 32'hFFFF_FFF0, 2'b01, "wrap_reload");
    chk(STAT,         32'h1,         2'b01, "wrap_stat");
    chk(BASE + 32'h8, 32'h7,         2'b01, "wrap_tcon");

    // Ch1 with prescaler (or per-cycle ticking when built without it)
    reset_pulse();
    wreg(BASE + 32'h1C, 32'h3);
    wreg(BASE + 32'h14, 32'hFFFF_FFFE);
    wreg(BASE + 32'h18, 32'h3);
`ifdef TIMER_BANK_PRESCALE_EN
    idle();
    idle();
    idle();
    chk(BASE + 32'h14, 32'hFFFF_FFFE, 2'b00, "pre_hold");
    chk(BASE + 32'h14, 32'hFFFF_FFFF, 2'b00, "pre_tick1");
    idle();
    idle();
    chk(BASE + 32'h14, 32'hFFFF_FFFF, 2'b00, "pre_hold2");
    chk(BASE + 32'h14, 32'h0,         2'b10, "pre_wrap");
    chk(BASE + 32'h1C, 32'h3,         2'b10, "pre_read");
`else
    chk(BASE + 32'h14, 32'hFFFF_FFFE, 2'b00, "nopre_t0");
    chk(BASE + 32'h14, 32'hFFFF_FFFF, 2'b00, "nopre_t1");
    chk(BASE + 32'h14, 32'h0,         2'b10, "nopre_wrap");
    chk(BASE + 32'h1C, 32'h0,         2'b10, "nopre_read");
`endif

    // One-shot stops after a single wrap
    reset_pulse();
    wreg(BASE + 32'h0, 32'h55);
    wreg(BASE + 32'h4, 32'hFFFF_FFFF);
    wreg(BASE + 32'hC, 32'h0);
    wreg(BASE + 32'h8, 32'hB);
    idle();
    chk(BASE + 32'h4, 32'h55, 2'b01, "oneshot_tl");
    chk(BASE + 32'h8, 32'hE,  2'b01, "oneshot_tcon");
    chk(BASE + 32'h4, 32'h55, 2'b01, "oneshot_hold");

    // Pending set beats W1C in the same cycle; later W1C clears
    reset_pulse();
    wreg(BASE + 32'h4, 32'hFFFF_FFFE);
    wreg(BASE + 32'h8, 32'h3);
    idle();
    wreg(BASE + 32'h8, 32'h7);
    chk(BASE + 32'h8, 32'h7, 2'b01, "set_over_clr");
    wreg(BASE + 32'h8, 32'h7);
    chk(BASE + 32'h8, 32'h3, 2'b00, "w1c_clear");

    // CPU TL write beats the tick
    wreg(BASE + 32'h4, 32'h1234_5678);
    chk(BASE + 32'h4, 32'h1234_5678, 2'b00, "tl_write_wins");

    // Reset while counting
    wreg(BASE + 32'h10, 32'hABCD);
    reset = 1'b0;
    model_clear();
    chk(BASE + 32'h4,  32'h0, 2'b00, "midrst_tl0");
    chk(BASE + 32'h8,  32'h0, 2'b00, "midrst_tcon0");
    chk(BASE + 32'h10, 32'h0, 2'b00, "midrst_th1");
    chk(STAT,          32'h0, 2'b00, "midrst_stat");
    reset = 1'b1;
    idle();
    idle();
    chk(BASE + 32'h4, 32'h0, 2'b00, "postrst_hold");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) != 0);
      a = rand_addr();
      bus(r, w, a, rand_data(a), 1'b0, '0, '0, "model_rd");
      if ($urandom_range(0, 399) == 0) reset_pulse();
    end
    for (int i = 0; i < int'(NUM_CH); i++) begin
      mread(BASE + 32'(16 * i) + 32'h4);
      mread(BASE + 32'(16 * i) + 32'h8);
    end
    mread(STAT);

    idle();
    end_req = 1'b1;
    idle();
    end_req = 1'b0;
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
